bus_cycle_gen: RTL and testbench
================================

// Module: bus_cycle_gen
// PURPOSE
//  Bus master for the 8085-style system bus: converts single-beat request/response transactions
//  into T1-T4 bus cycles on ALE, IOM, RD, WR, Address and Data. Sits directly upstream of the
//  I/O and memory slave devices and drives the shared bus they decode.
//  One transaction in flight at a time; 4 CLK cycles per transaction without wait states.
// PARAMETERS
//  ADDR_W     16       address width
//  DATA_W     8        data bus width
//  IDLE_ADDR  16'h0000 value driven on Address when no cycle is active
// PORTS
//  CLK        in     1       bus clock; all state changes on posedge
//  RESET      in     1       synchronous, active-high
//  req_valid  in     1       request present
//  req_ready  out    1       request accepted when req_valid && req_ready at posedge
//  req_write  in     1       1=write cycle, 0=read cycle
//  req_io     in     1       1=I/O space (IOM=1), 0=memory space
//  req_addr   in     ADDR_W  target address
//  req_wdata  in     DATA_W  write data
//  rsp_valid  out    1       one-cycle pulse: transaction complete
//  rsp_rdata  out    DATA_W  read data, valid with rsp_valid; 0 for writes
//  ALE        out    1       address latch enable, high in T1 only
//  IOM        out    1       I/O-vs-memory select, stable T1..T4
//  RD         out    1       read strobe, active-low
//  WR         out    1       write strobe, active-low
//  Address    out    ADDR_W  bus address, stable T1..T4
//  Data       inout  DATA_W  bidirectional data bus
//  READY      in     1       slave ready; used only with WAIT_STATE_EN
// BEHAVIOUR
//  - States: IDLE, T1, T2, T3, T4 (+TW with WAIT_STATE_EN); one-hot encoding.
//  - All bus outputs decode the registered state and captured registers only; no combinational path req_* -> bus.
//  - req_ready = 1 in IDLE and T4, else 0. On acceptance, req_write/io/addr/wdata latched; next state T1.
//  - IDLE: no req -> IDLE. T1 -> T2 -> T3 -> T4 unconditionally (without WAIT_STATE_EN).
//  - T4: new request accepted -> T1 (back-to-back, 4-cycle throughput); otherwise -> IDLE.
//  - T1: ALE=1, IOM=captured io, Address=captured addr, RD=WR=1, Data=Z.
//  - T2,T3: read -> RD=0; write -> WR=0 and Data driven with wdata. ALE=0.
//  - T4: RD=WR=1; write data still driven (hold); Address/IOM held.
//  - Read data sampled from Data at the posedge leaving T3; rsp_valid=1 and rsp_rdata valid during T4.
//  - Latency: request accepted at posedge k -> T1 in cycle k+1 -> rsp_valid in cycle k+4.
//  - IDLE bus: ALE=0, IOM=0, RD=WR=1, Address=IDLE_ADDR, Data=Z.
//  - RD and WR are never low simultaneously; Data is never driven during a read cycle or in IDLE/T1.
//  - RESET (any state, including mid-cycle): next state IDLE, in-flight transaction dropped, no rsp_valid.
//  - Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, ALE=0, IOM=0, RD=1, WR=1, Address=IDLE_ADDR, Data=Z.
// CONFIGURATION
//  WAIT_STATE_EN defined: READY sampled at posedge leaving T2 and each TW.
//    READY=0 -> TW, holding T2 strobes/data. READY=1 -> T3. Read data still sampled leaving T3.
//  WAIT_STATE_EN undefined: TW state absent; READY ignored; fixed 4-cycle bus cycle.
// STRUCTURE
//  - bus_pkg: bus_state_e enum; bus constants ADDR_W/DATA_W defaults; IO_BASE=16'h1C00; IO_LAST=16'h1DFF.
//  - Sub-module bus_data_pad: tristate driver and input sampler for Data (oe, dout, din).
// TESTING
//  - Read: req io=1 addr=16'h1C05; slave model returns 8'hA5 in T3 -> ALE 1 cycle, RD low 2 cycles, rsp_rdata=8'hA5 in T4.
//  - Write: req io=1 addr=16'h1C10 wdata=8'h3C -> WR low in T2,T3; Data=8'h3C T2..T4; slave reads back 8'h3C.
//  - Back-to-back: req_valid held with 3 requests -> ALE pulses exactly 4 cycles apart; 3 rsp_valid pulses.
//  - Reset mid-cycle: RESET asserted in T2 of a read -> next cycle RD=1, Data=Z, state IDLE, no rsp_valid.
//  - Memory cycle: req io=0 addr=16'h0040 -> IOM=0 T1..T4; I/O slave at 16'h1C00..16'h1DFF stays idle.
//  - WAIT_STATE_EN: READY=0 for 2 samples -> RD low 4 cycles, rsp_valid in cycle k+6.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the 8085-style bus master and its slave decoders.
package bus_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;
  localparam logic [15:0] IO_BASE    = 16'h1C00;
  localparam logic [15:0] IO_LAST    = 16'h1DFF;

  // One-hot bus cycle phases; TW only reachable with wait states enabled
  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    T1   = 6'b000010,
    T2   = 6'b000100,
    T3   = 6'b001000,
    T4   = 6'b010000,
    TW   = 6'b100000
  } bus_state_e;

  // Phases in which the active strobe (RD or WR) is asserted
  function automatic logic is_strobe_state(input bus_state_e s);
    return (s == T2) || (s == T3) || (s == TW);
  endfunction

endpackage

// File: rtl/bus_data_pad.sv
// Tristate driver and input sampler for the shared Data bus.
module bus_data_pad #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_oe,
  input  logic [DATA_W-1:0] i_dout,
  output logic [DATA_W-1:0] o_din,
  inout  wire  [DATA_W-1:0] io_pad
);

  assign io_pad = i_oe ? i_dout : {DATA_W{1'bz}};
  assign o_din  = io_pad;

endmodule

// File: rtl/bus_cycle_gen.sv
// Bus master turning single-beat requests into T1-T4 bus cycles.
// Define WAIT_STATE_EN to insert TW states while READY is low.
module bus_cycle_gen
  import bus_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_io,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ALE,
  output logic              IOM,
  output logic              RD,
  output logic              WR,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data,
  input  logic              READY
);

  bus_state_e        r_state;
  bus_state_e        w_next_state;
  logic              w_accept;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_ale;
  logic              r_iom;
  logic              r_rd_n;
  logic              r_wr_n;
  logic [ADDR_W-1:0] r_address;
  logic              r_data_oe;
  logic [DATA_W-1:0] w_din;

`ifndef WAIT_STATE_EN
  logic w_unused_ready;
  assign w_unused_ready = READY;
`endif

  // Next-phase decode
  always_comb begin
    w_next_state = r_state;
    w_accept     = req_valid && ((r_state == IDLE) || (r_state == T4));
    case (r_state)
      IDLE: w_next_state = w_accept ? T1 : IDLE;
      T1:   w_next_state = T2;
`ifdef WAIT_STATE_EN
      T2:   w_next_state = READY ? T3 : TW;
      TW:   w_next_state = READY ? T3 : TW;
`else
      T2:   w_next_state = T3;
      TW:   w_next_state = IDLE;
`endif
      T3:   w_next_state = T4;
      T4:   w_next_state = w_accept ? T1 : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Bus outputs are registered from the next phase so they change cleanly on CLK
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_ale       <= 1'b0;
      r_iom       <= 1'b0;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_address   <= IDLE_ADDR;
      r_data_oe   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_write   <= req_write;
        r_wdata   <= req_wdata;
        r_iom     <= req_io;
        r_address <= req_addr;
      end else if (w_next_state == IDLE) begin
        r_iom     <= 1'b0;
        r_address <= IDLE_ADDR;
      end
      r_ale       <= (w_next_state == T1);
      r_req_ready <= (w_next_state == IDLE) || (w_next_state == T4);
      r_rd_n      <= !(is_strobe_state(w_next_state) && !r_write);
      r_wr_n      <= !(is_strobe_state(w_next_state) && r_write);
      r_data_oe   <= r_write && (is_strobe_state(w_next_state) || (w_next_state == T4));
      r_rsp_valid <= (w_next_state == T4);
      r_rsp_rdata <= ((r_state == T3) && !r_write) ? w_din : '0;
    end
  end

  bus_data_pad #(
    .DATA_W (DATA_W)
  ) u_data_pad (
    .i_oe   (r_data_oe),
    .i_dout (r_wdata),
    .o_din  (w_din),
    .io_pad (Data)
  );

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign ALE       = r_ale;
  assign IOM       = r_iom;
  assign RD        = r_rd_n;
  assign WR        = r_wr_n;
  assign Address   = r_address;

endmodule

// File: tb/tb_bus_cycle_gen.sv
// Self-checking bench for bus_cycle_gen: directed table, corner sequences, random traffic.
module tb_bus_cycle_gen;
  import bus_pkg::*;

  localparam int unsigned NCYC = 2048;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid, req_ready, req_write, req_io;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        ALE, IOM, RD, WR;
  logic [15:0] Address;
  wire  [7:0]  Data;
  logic        READY;

  always #5 CLK = ~CLK;

  bus_cycle_gen dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR),
    .Address(Address), .Data(Data), .READY(READY)
  );

  function automatic logic [7:0] init_io(input int i);
    return (i == 5) ? 8'hA5 : 8'(i * 13 + 7);
  endfunction
  function automatic logic [7:0] init_mem(input int i);
    return 8'(i * 29 + 101);
  endfunction

  // Slave devices: I/O window at IO_BASE..IO_LAST and a 256-byte memory
  logic [7:0] io_mem [512];
  logic [7:0] mem    [256];
  logic       slave_init_done = 1'b0;
  logic [8:0] w_io_idx;
  logic [7:0] slave_dout;
  int         io_act = 0;
  int         iom_hi = 0;

  assign w_io_idx   = 9'(Address - IO_BASE);
  assign slave_dout = IOM ? io_mem[w_io_idx] : mem[Address[7:0]];
  assign Data       = !RD ? slave_dout : 8'bz;

  always @(posedge CLK) begin
    if (!slave_init_done) begin
      for (int i = 0; i < 512; i++) io_mem[i] <= init_io(i);
      for (int i = 0; i < 256; i++) mem[i] <= init_mem(i);
      slave_init_done <= 1'b1;
    end else if (!WR) begin
      if (IOM) io_mem[w_io_idx] <= Data;
      else     mem[Address[7:0]] <= Data;
    end
    if (IOM && Address >= IO_BASE && Address <= IO_LAST && (!RD || !WR)) io_act <= io_act + 1;
    if (IOM) iom_hi <= iom_hi + 1;
  end

  // Reference model: per-cycle expected bus timeline scheduled at each acceptance
  logic       e_ale [NCYC], e_iom [NCYC], e_rd_n [NCYC], e_wr_n [NCYC];
  logic       e_valid [NCYC], e_drive [NCYC];
  logic [15:0] e_addr [NCYC];
  logic [7:0] e_rdata [NCYC], e_data [NCYC];
  logic [7:0] ref_io [512];
  logic [7:0] ref_mem [256];
  int         cyc = 0;
  int         last_t1 = -100;
  logic       model_en = 1'b1;
  logic       pend_wr = 1'b0;
  int         pend_cyc;
  logic       pend_io;
  logic [15:0] pend_addr;
  logic [7:0] pend_data;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic logic [8:0] io_idx(input logic [15:0] a);
    return 9'(a - IO_BASE);
  endfunction

  task automatic clear_from(input int c);
    for (int k = c; k < NCYC; k++) begin
      e_ale[k] = 1'b0; e_iom[k] = 1'b0; e_rd_n[k] = 1'b1; e_wr_n[k] = 1'b1;
      e_valid[k] = 1'b0; e_drive[k] = 1'b0; e_addr[k] = 16'h0000;
      e_rdata[k] = 8'h00; e_data[k] = 8'h00;
    end
  endtask

  task automatic schedule(input int n, input logic wr, input logic io,
                          input logic [15:0] a, input logic [7:0] wd);
    last_t1 = n;
    for (int k = n; k < n + 4; k++) begin
      e_iom[k]  = io;
      e_addr[k] = a;
    end
    e_ale[n] = 1'b1;
    if (wr) begin
      e_wr_n[n+1] = 1'b0; e_wr_n[n+2] = 1'b0;
      for (int k = n + 1; k < n + 4; k++) begin
        e_drive[k] = 1'b1;
        e_data[k]  = wd;
      end
      pend_wr = 1'b1; pend_cyc = n + 2; pend_io = io; pend_addr = a; pend_data = wd;
      e_rdata[n+3] = 8'h00;
    end else begin
      e_rd_n[n+1] = 1'b0; e_rd_n[n+2] = 1'b0;
      e_rdata[n+3] = io ? ref_io[io_idx(a)] : ref_mem[a[7:0]];
    end
    e_valid[n+3] = 1'b1;
  endtask

  task automatic check_cycle(input int c);
    logic bad;
    logic exp_ready;
    exp_ready = (c >= last_t1 + 3);
    bad = (ALE !== e_ale[c]) || (IOM !== e_iom[c]) || (RD !== e_rd_n[c]) || (WR !== e_wr_n[c])
       || (Address !== e_addr[c]) || (req_ready !== exp_ready) || (rsp_valid !== e_valid[c])
       || (e_valid[c] && (rsp_rdata !== e_rdata[c])) || (e_drive[c] && (Data !== e_data[c]));
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL model cyc=%0d ale=%b/%b iom=%b/%b rd=%b/%b wr=%b/%b addr=%h/%h rdy=%b/%b vld=%b/%b rdata=%h/%h data=%h/%h(drv %b) (got/exp)",
               c, ALE, e_ale[c], IOM, e_iom[c], RD, e_rd_n[c], WR, e_wr_n[c], Address, e_addr[c],
               req_ready, exp_ready, rsp_valid, e_valid[c], rsp_rdata, e_rdata[c], Data, e_data[c], e_drive[c]);
    end
  endtask

  // One bus clock: drive inputs, advance model on the edge, compare 1ns later
  task automatic cycle(input logic rv, input logic wr, input logic io, input logic [15:0] a,
                       input logic [7:0] wd, input logic rst, input logic rdy);
    logic acc;
    RESET = rst; req_valid = rv; req_write = wr; req_io = io;
    req_addr = a; req_wdata = wd; READY = rdy;
    acc = model_en && !rst && rv && (cyc >= last_t1 + 3);
    @(posedge CLK);
    cyc++;
    if (pend_wr && cyc >= pend_cyc) begin
      if (pend_io) ref_io[io_idx(pend_addr)] = pend_data;
      else         ref_mem[pend_addr[7:0]] = pend_data;
      pend_wr = 1'b0;
    end
    if (rst) begin
      clear_from(cyc);
      last_t1 = -100;
      pend_wr = 1'b0;
    end else if (acc) begin
      schedule(cyc, wr, io, a, wd);
    end
    #1;
    if (model_en) check_cycle(cyc);
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic        rv, wr, io;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        e_ale, e_rd_n, e_wr_n, e_valid;
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int ale_cnt, rsp_cnt, last_ale, gap_bad, io_before, iom_before;
    logic rv, wr, io;
    logic [15:0] a;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'h1C05, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 16'h1C10, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 16'h1C10, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};

    for (int i = 0; i < 512; i++) ref_io[i] = init_io(i);
    for (int i = 0; i < 256; i++) ref_mem[i] = init_mem(i);
    clear_from(0);

    cycle(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);

    // Directed read / write / read-back
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].rv, tbl[i].wr, tbl[i].io, tbl[i].addr, tbl[i].wd, 1'b0, 1'b1);
      vectors++;
      if (ALE !== tbl[i].e_ale || RD !== tbl[i].e_rd_n || WR !== tbl[i].e_wr_n ||
          rsp_valid !== tbl[i].e_valid || (tbl[i].e_valid && rsp_rdata !== tbl[i].e_rdata)) begin
        miscompares++;
        $display("FAIL table row=%0d ale=%b/%b rd=%b/%b wr=%b/%b vld=%b/%b rdata=%h/%h (got/exp)",
                 i, ALE, tbl[i].e_ale, RD, tbl[i].e_rd_n, WR, tbl[i].e_wr_n,
                 rsp_valid, tbl[i].e_valid, rsp_rdata, tbl[i].e_rdata);
      end
    end

    // Back-to-back: req_valid held for three transactions
    ale_cnt = 0; rsp_cnt = 0; last_ale = -1; gap_bad = 0;
    for (int i = 0; i < 13; i++) begin
      cycle(i < 9, 1'b0, 1'b0, 16'h0040 + 16'(i), 8'h00, 1'b0, 1'b1);
      if (ALE) begin
        if (last_ale >= 0 && cyc - last_ale != 4) gap_bad++;
        last_ale = cyc;
        ale_cnt++;
      end
      if (rsp_valid) rsp_cnt++;
    end
    expect_int("b2b_ale_count", ale_cnt, 3);
    expect_int("b2b_ale_gap_errors", gap_bad, 0);
    expect_int("b2b_rsp_count", rsp_cnt, 3);

    // Reset asserted during T2 of a read
    cycle(1'b1, 1'b0, 1'b1, 16'h1C05, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
    expect_int("rst_mid_rd", int'(RD), 1);
    expect_int("rst_mid_rsp_valid", int'(rsp_valid), 0);
    rsp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1);
      if (rsp_valid) rsp_cnt++;
    end
    expect_int("rst_mid_no_rsp", rsp_cnt, 0);

    // Memory-space write then read back; I/O slave must stay quiet
    io_before = io_act; iom_before = iom_hi;
    cycle(1'b1, 1'b1, 1'b0, 16'h0040, 8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 16'h0040, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
    expect_int("mem_rdata", int'(rsp_rdata), 'h5A);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
    expect_int("mem_io_slave_activity", io_act - io_before, 0);
    expect_int("mem_iom_high_cycles", iom_hi - iom_before, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rv = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 1) == 1);
      io = ($urandom_range(0, 1) == 1);
      a  = io ? IO_BASE + 16'($urandom_range(0, 511)) : 16'($urandom_range(0, 255));
`ifdef WAIT_STATE_EN
      cycle(rv, wr, io, a, 8'($urandom), ($urandom_range(0, 99) == 0), 1'b1);
`else
      cycle(rv, wr, io, a, 8'($urandom), ($urandom_range(0, 99) == 0), 1'($urandom));
`endif
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);

`ifdef WAIT_STATE_EN
    // Two READY-low samples stretch the read strobe to four cycles
    begin
      int t1_cyc, rd_low, rsp_cyc;
      logic [7:0] got;
      model_en = 1'b0;
      rd_low = 0; rsp_cyc = -1; got = 8'h00; t1_cyc = cyc + 1;
      for (int i = 0; i < 8; i++) begin
        cycle(i == 0, 1'b0, 1'b1, 16'h1C05, 8'h00, 1'b0, !(i == 2 || i == 3));
        if (!RD) rd_low++;
        if (rsp_valid) begin
          rsp_cyc = cyc;
          got = rsp_rdata;
        end
      end
      expect_int("wait_rd_low_cycles", rd_low, 4);
      expect_int("wait_rsp_latency", rsp_cyc - t1_cyc, 5);
      expect_int("wait_rdata", int'(got), int'(ref_io[5]));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
